// File: rtl/branch_target_buffer_nway_pkg.sv
// branch_target_buffer_nway_pkg: shared LRU age-step and direction-counter helpers for the BTB
package branch_target_buffer_nway_pkg;
  function automatic int unsigned age_next(input int unsigned age, input int unsigned touched_age);
    return (age == touched_age) ? 0 : (age < touched_age) ? age + 1 : age;
  endfunction
  function automatic int unsigned cnt_step(input int unsigned cnt, input logic up, input int unsigned cnt_w);
    return up ? ((cnt == (32'd1 << cnt_w) - 1) ? cnt : cnt + 1) : ((cnt == 0) ? 0 : cnt - 1);
  endfunction
  function automatic int unsigned weak_taken(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction
endpackage

// File: rtl/branch_target_buffer_nway_lru_set.sv
// branch_target_buffer_nway_lru_set: one set's true-LRU age vector and victim choice
//   clk, rst_n          clock, async active-low reset (ages return to age[w]=w)
//   flush               ages return to age[w]=w
//   touch, touch_way    make touch_way MRU
//   valid               per-way valid mask of this set
//   victim              lowest invalid way, else the oldest way
module branch_target_buffer_nway_lru_set
  import branch_target_buffer_nway_pkg::*;
#(
  parameter int WAY_N = 2,
  parameter int WAY_W = $clog2(WAY_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [WAY_N-1:0] valid,
  output logic [WAY_W-1:0] victim
);
  logic [WAY_W-1:0] age [WAY_N];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int w = 0; w < WAY_N; w++) age[w] <= WAY_W'(w);
    else for (int w = 0; w < WAY_N; w++)
      age[w] <= flush ? WAY_W'(w) : touch ? WAY_W'(age_next(32'(age[w]), 32'(age[touch_way]))) : age[w];
  // Descending scans so the lowest index wins; invalid ways override the oldest way.
  always_comb begin
    victim = '0;
    for (int w = WAY_N - 1; w >= 0; w--) if (age[w] == WAY_W'(WAY_N - 1)) victim = WAY_W'(w);
    for (int w = WAY_N - 1; w >= 0; w--) if (!valid[w]) victim = WAY_W'(w);
  end
endmodule

// File: rtl/branch_target_buffer_nway.sv
// branch_target_buffer_nway: N-way set-associative BTB with saturating direction counters and true-LRU
//   clk, rst_n                   clock, async active-low reset
//   flush                        invalidate every entry
//   search_stb/search_inst_addr  fetch lookup; registered result one cycle later
//   search_valid/hit/predict_branch/addr   lookup result (addr=0 on miss)
//   jump_stb/valid/addr/inst_addr          resolved-branch update from execute
module branch_target_buffer_nway
  import branch_target_buffer_nway_pkg::*;
#(
  parameter int SET_N  = 16,
  parameter int WAY_N  = 2,
  parameter int CNT_W  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              search_stb,
  input  logic [ADDR_W-1:0] search_inst_addr,
  output logic              search_valid,
  output logic              search_hit,
  output logic              search_predict_branch,
  output logic [ADDR_W-1:0] search_addr,
  input  logic              jump_stb,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] jump_inst_addr
);
  localparam int IDX_W = $clog2(SET_N);
  localparam int WAY_W = $clog2(WAY_N);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  logic [WAY_N-1:0]  valid  [SET_N];
  logic [TAG_W-1:0]  tag    [SET_N][WAY_N];
  logic [ADDR_W-1:0] target [SET_N][WAY_N];
  logic [CNT_W-1:0]  cnt    [SET_N][WAY_N];
  logic [IDX_W-1:0] s_idx, j_idx;
  logic [TAG_W-1:0] s_tag, j_tag;
  logic [WAY_W-1:0] s_way, j_way, j_sel;
  logic             s_hit, j_hit, s_ok, upd, s_touch;
  logic [SET_N-1:0] touch;
  logic [WAY_W-1:0] touch_way [SET_N];
  logic [WAY_W-1:0] victim    [SET_N];
  logic             unused_low;
  assign unused_low = ^{search_inst_addr[1:0], jump_inst_addr[1:0]};
  assign s_idx = search_inst_addr[IDX_W+1:2];
  assign s_tag = search_inst_addr[ADDR_W-1:IDX_W+2];
  assign j_idx = jump_inst_addr[IDX_W+1:2];
  assign j_tag = jump_inst_addr[ADDR_W-1:IDX_W+2];
  always_comb begin
    s_hit = 1'b0;
    s_way = '0;
    j_hit = 1'b0;
    j_way = '0;
    for (int w = 0; w < WAY_N; w++) begin
      if (valid[s_idx][w] && tag[s_idx][w] == s_tag) begin
        s_hit = 1'b1;
        s_way = WAY_W'(w);
      end
      if (valid[j_idx][w] && tag[j_idx][w] == j_tag) begin
        j_hit = 1'b1;
        j_way = WAY_W'(w);
      end
    end
  end
  // A miss that is not taken leaves the set untouched.
  assign upd     = jump_stb && !flush && (j_hit || jump_valid);
  assign j_sel   = j_hit ? j_way : victim[j_idx];
  assign s_ok    = search_stb && !flush;
  // When the update lands in the searched set only the update's recency counts.
  assign s_touch = s_ok && s_hit && !(upd && j_idx == s_idx);
  always_comb
    for (int s = 0; s < SET_N; s++) begin
      touch[s]     = (upd && j_idx == IDX_W'(s)) || (s_touch && s_idx == IDX_W'(s));
      touch_way[s] = (upd && j_idx == IDX_W'(s)) ? j_sel : s_way;
    end
  for (genvar s = 0; s < SET_N; s++) begin : g_set
    branch_target_buffer_nway_lru_set #(.WAY_N(WAY_N)) u_lru (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .touch    (touch[s]),
      .touch_way(touch_way[s]),
      .valid    (valid[s]),
      .victim   (victim[s])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int s = 0; s < SET_N; s++) begin
        valid[s] <= '0;
        for (int w = 0; w < WAY_N; w++) cnt[s][w] <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < SET_N; s++) valid[s] <= '0;
    end else if (upd) begin
      valid[j_idx][j_sel] <= 1'b1;
      cnt[j_idx][j_sel]   <= j_hit ? CNT_W'(cnt_step(32'(cnt[j_idx][j_sel]), jump_valid, CNT_W))
                                   : CNT_W'(weak_taken(CNT_W));
    end
  // Tag and target storage carries no reset; valid gates every use.
  always_ff @(posedge clk)
    if (upd && jump_valid) begin
      tag[j_idx][j_sel]    <= j_tag;
      target[j_idx][j_sel] <= jump_addr;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      search_valid          <= 1'b0;
      search_hit            <= 1'b0;
      search_predict_branch <= 1'b0;
      search_addr           <= '0;
    end else begin
      search_valid          <= s_ok;
      search_hit            <= s_ok && s_hit;
      search_predict_branch <= s_ok && s_hit && cnt[s_idx][s_way][CNT_W-1];
      search_addr           <= (s_ok && s_hit) ? target[s_idx][s_way] : '0;
    end
endmodule
